// File: rtl/qspi_flash_reader.sv
// Quad-SPI Fast Read Quad Output (0x6B) engine feeding the flash cache buffer.
// Optional QSPI_FLASH_READER_HOLD_CS_EN keeps chip select low while paused.
module qspi_flash_reader #(
    parameter int DUMMY_CYCLES   = 8,
    parameter int CS_HIGH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        qspi_enable,
    input  logic [23:0] qspi_address,
    input  logic        qspi_changeAddress,
    input  logic        qspi_requestData,
    output logic [31:0] qspi_readData,
    output logic        qspi_readDataValid,
    output logic        flash_csb,
    output logic        flash_sck,
    output logic [3:0]  flash_io_we,
    output logic [3:0]  flash_io_write,
    input  logic [3:0]  flash_io_read
);

    typedef enum logic [2:0] {
        IDLE,
        CS_GAP,
        COMMAND,
        ADDRESS,
        DUMMY,
        DATA,
        WORD_END,
        PAUSE
    } state_t;

    localparam logic [7:0] CMD_READ   = 8'h6B;
    localparam logic [7:0] CMD_LAST   = 8'd7;
    localparam logic [7:0] ADDR_LAST  = 8'd23;
    localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);
    localparam logic [7:0] DATA_LAST  = 8'd7;
    localparam logic [7:0] GAP_LOAD   =
        8'((CS_HIGH_CYCLES > 0) ? CS_HIGH_CYCLES - 1 : 0);
    localparam state_t AFTER_ADDR = (DUMMY_CYCLES > 0) ? DUMMY : DATA;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  gap_q, gap_d;
    logic        sck_q, sck_d;
    logic        csb_q, csb_d;
    logic [3:0]  we_q, we_d;
    logic [3:0]  wr_q, wr_d;
    logic [23:0] addr_q, addr_d;
    logic [31:0] word_q, word_d;
    logic [31:0] rdata_q, rdata_d;
    logic        valid_q, valid_d;

    logic        abort;
    logic [7:0]  slot_last;
    state_t      phase_next;
    logic [4:0]  nib_lsb;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = ^qspi_address[1:0];
    assign abort = qspi_changeAddress || !qspi_enable;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        sck_d      = 1'b0;
        addr_d     = addr_q;
        word_d     = word_q;
        rdata_d    = rdata_q;
        valid_d    = 1'b0;
        slot_last  = DATA_LAST;
        phase_next = WORD_END;
        // high nibble of each byte arrives first
        nib_lsb    = {cnt_q[2:1], ~cnt_q[0], 2'b00};

        unique case (state_q)
            COMMAND: begin
                slot_last  = CMD_LAST;
                phase_next = ADDRESS;
            end
            ADDRESS: begin
                slot_last  = ADDR_LAST;
                phase_next = AFTER_ADDR;
            end
            DUMMY: begin
                slot_last  = DUMMY_LAST;
                phase_next = DATA;
            end
            default: ;
        endcase

        if (qspi_changeAddress) begin
            addr_d = {qspi_address[23:2], 2'b00};
        end

        if (abort) begin
            state_d = CS_GAP;
            cnt_d   = '0;
            gap_d   = GAP_LOAD;
            word_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (qspi_requestData) begin
                        state_d = COMMAND;
                        cnt_d   = '0;
                    end
                end
                CS_GAP: begin
                    if (gap_q == 8'd0) begin
                        state_d = IDLE;
                    end else begin
                        gap_d = gap_q - 8'd1;
                    end
                end
                COMMAND, ADDRESS, DUMMY, DATA: begin
                    if (!sck_q) begin
                        sck_d = 1'b1;
                        if (state_q == DATA) begin
                            word_d[nib_lsb +: 4] = flash_io_read;
                        end
                    end else if (cnt_q == slot_last) begin
                        cnt_d   = '0;
                        state_d = phase_next;
                        if (state_q == DATA) begin
                            valid_d = 1'b1;
                            rdata_d = word_q;
                            addr_d  = addr_q + 24'd4;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                WORD_END: begin
                    if (qspi_requestData) begin
                        state_d = DATA;
                    end else begin
`ifdef QSPI_FLASH_READER_HOLD_CS_EN
                        state_d = PAUSE;
`else
                        state_d = CS_GAP;
                        gap_d   = GAP_LOAD;
`endif
                    end
                end
                PAUSE: begin
                    if (qspi_requestData) begin
                        state_d = DATA;
                    end
                end
            endcase
        end

        // pad lines are registered from the next state so they change with sck low
        csb_d = 1'b1;
        we_d  = 4'b1100;
        wr_d  = 4'b1100;
        unique case (state_d)
            COMMAND: begin
                csb_d = 1'b0;
                we_d  = 4'b1101;
                wr_d  = {3'b110, CMD_READ[~cnt_d[2:0]]};
            end
            ADDRESS: begin
                csb_d = 1'b0;
                we_d  = 4'b1101;
                wr_d  = {3'b110, addr_q[5'(ADDR_LAST - cnt_d)]};
            end
            DUMMY, DATA, WORD_END, PAUSE: begin
                csb_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            sck_q   <= 1'b0;
            csb_q   <= 1'b1;
            we_q    <= 4'b1100;
            wr_q    <= 4'b1100;
            addr_q  <= '0;
            word_q  <= '0;
            rdata_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            sck_q   <= sck_d;
            csb_q   <= csb_d;
            we_q    <= we_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
        end
    end

    assign qspi_readData      = rdata_q;
    assign qspi_readDataValid = valid_q;
    assign flash_csb          = csb_q;
    assign flash_sck          = sck_q;
    assign flash_io_we        = we_q;
    assign flash_io_write     = wr_q;

endmodule
